// File: rtl/accum_datapath_if.sv
// Control/status bundle between the accumulator CPU control unit (master)
// and its datapath (slave).
interface accum_datapath_if #(
  parameter int WIDTH = 8
);
  logic             IRload;
  logic             PCload;
  logic             JMPmux;
  logic             Meminst;
  logic             MemWr;
  logic [1:0]       Asel;
  logic             Aload;
  logic             Sub;
  logic             Halt;
  logic [WIDTH-1:0] Input;
  logic [2:0]       IR;
  logic             Aeq0;
  logic             Apos;
  logic [WIDTH-1:0] Output;

  modport master (
    output IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt, Input,
    input  IR, Aeq0, Apos, Output
  );

  modport slave (
    input  IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt, Input,
    output IR, Aeq0, Apos, Output
  );
endinterface

// File: rtl/accum_datapath.sv
// Register-transfer datapath of the 8-instruction accumulator CPU: PC, IR, MDR, A, unified RAM.
// Optional macro ACCUM_DP_PROG_EN adds a RAM programming port usable while Reset is held low.
module accum_datapath #(
  parameter int WIDTH = 8,
  parameter int AW    = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  accum_datapath_if.slave  bus
`ifdef ACCUM_DP_PROG_EN
  ,
  input  logic             ProgWr,
  input  logic [AW-1:0]    ProgAddr,
  input  logic [WIDTH-1:0] ProgData
`endif
);

  typedef enum logic [1:0] {
    ASEL_ALU   = 2'b00,
    ASEL_INPUT = 2'b01,
    ASEL_MDR   = 2'b10,
    ASEL_ZERO  = 2'b11
  } asel_e;

  logic [AW-1:0]    r_pc;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_mdr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_ram [2**AW];

  logic             w_run;
  logic             w_mem_we;
  logic             w_aeq0;
  logic [AW-1:0]    w_addr;
  logic [AW-1:0]    w_pc_next;
  logic [WIDTH-1:0] w_rd;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_a_next;

  assign w_run     = ~bus.Halt;
  assign w_mem_we  = w_run & bus.MemWr;
  assign w_addr    = bus.Meminst ? r_ir[AW-1:0] : r_pc;
  assign w_rd      = r_ram[w_addr];
  assign w_alu     = bus.Sub ? (r_a - r_mdr) : (r_a + r_mdr);
  assign w_pc_next = bus.JMPmux ? r_ir[AW-1:0] : (r_pc + AW'(1));

  always_comb begin
    // NOTE: assign a default before the case so no path leaves w_a_next unassigned (no latch).
    w_a_next = r_a;
    case (asel_e'(bus.Asel))
      ASEL_ALU:   w_a_next = w_alu;
      ASEL_INPUT: w_a_next = bus.Input;
      ASEL_MDR:   w_a_next = r_mdr;
      ASEL_ZERO:  w_a_next = '0;
      default:    w_a_next = r_a;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mdr <= '0;
      r_a   <= '0;
    end else if (w_run) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values (fetch reads old PC).
      if (bus.Meminst && !bus.MemWr) r_mdr <= w_rd;
      if (bus.IRload)                r_ir  <= w_rd;
      if (bus.PCload)                r_pc  <= w_pc_next;
      if (bus.Aload)                 r_a   <= w_a_next;
    end
  end

  // NOTE: the RAM has no reset branch; clearing a memory array would defeat RAM inference.
  always_ff @(posedge Clock) begin
`ifdef ACCUM_DP_PROG_EN
    if (!Reset) begin
      if (ProgWr) r_ram[ProgAddr] <= ProgData;
    end else if (w_mem_we) begin
      r_ram[w_addr] <= r_a;
    end
`else
    if (w_mem_we) r_ram[w_addr] <= r_a;
`endif
  end

  assign w_aeq0     = (r_a == '0);
  assign bus.IR     = r_ir[WIDTH-1:WIDTH-3];
  assign bus.Aeq0   = w_aeq0;
  assign bus.Apos   = ~r_a[WIDTH-1] & ~w_aeq0;
  assign bus.Output = r_a;

endmodule

// File: tb/tb_accum_datapath.sv
// Self-checking bench for accum_datapath: directed scenarios plus randomized control words
// compared against a cycle-level behavioural model of the accumulator datapath.
module tb_accum_datapath;
  localparam int WIDTH = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  accum_datapath_if #(.WIDTH(WIDTH)) bus ();

`ifdef ACCUM_DP_PROG_EN
  logic             ProgWr   = 1'b0;
  logic [AW-1:0]    ProgAddr = '0;
  logic [WIDTH-1:0] ProgData = '0;
`endif

  accum_datapath #(.WIDTH(WIDTH), .AW(AW)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .bus      (bus)
`ifdef ACCUM_DP_PROG_EN
    ,
    .ProgWr   (ProgWr),
    .ProgAddr (ProgAddr),
    .ProgData (ProgData)
`endif
  );

  // Behavioural model state
  logic [7:0] m_ram [DEPTH];
  logic [4:0] m_pc;
  logic [7:0] m_ir, m_mdr, m_a;
  logic [7:0] prog [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_mdr = 0; m_a = 0;
  endtask

  // Next state from the rules: every register/RAM update uses values seen before the edge.
  task automatic model_step();
    logic [4:0] addr;
    logic [7:0] rd, a_old, mdr_old, ir_old;
    if (!Reset) begin
`ifdef ACCUM_DP_PROG_EN
      if (ProgWr) m_ram[ProgAddr] = ProgData;
`endif
      return;
    end
    if (bus.Halt) return;
    addr    = bus.Meminst ? m_ir[4:0] : m_pc;
    rd      = m_ram[addr];
    a_old   = m_a;
    mdr_old = m_mdr;
    ir_old  = m_ir;
    if (bus.MemWr) m_ram[addr] = a_old;
    if (bus.Meminst && !bus.MemWr) m_mdr = rd;
    if (bus.IRload) m_ir = rd;
    if (bus.PCload) m_pc = bus.JMPmux ? ir_old[4:0] : m_pc + 5'd1;
    if (bus.Aload) begin
      case (bus.Asel)
        2'b00:   m_a = bus.Sub ? a_old - mdr_old : a_old + mdr_old;
        2'b01:   m_a = bus.Input;
        2'b10:   m_a = mdr_old;
        default: m_a = 8'h00;
      endcase
    end
  endtask

  // Argument order: IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub, Halt, Input
  task automatic step(input logic irl, input logic pcl, input logic jmp, input logic mi,
                      input logic mw, input logic [1:0] asel, input logic al, input logic sb,
                      input logic hl, input logic [7:0] din);
    bus.IRload = irl; bus.PCload = pcl; bus.JMPmux = jmp; bus.Meminst = mi;
    bus.MemWr = mw; bus.Asel = asel; bus.Aload = al; bus.Sub = sb; bus.Halt = hl;
    bus.Input = din;
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();          step(0,0,0,0,0,2'b00,0,0,0,8'h00); endtask
  task automatic fetch();         step(1,1,0,0,0,2'b00,0,0,0,8'h00); endtask
  task automatic decode();        step(0,0,0,1,0,2'b00,0,0,0,8'h00); endtask
  task automatic load_in(input logic [7:0] v); step(0,0,0,0,0,2'b01,1,0,0,v); endtask
  task automatic load_mdr();      step(0,0,0,0,0,2'b10,1,0,0,8'h00); endtask

  task automatic test_reset();
    #2;
    n_checks++; if (bus.Output !== 8'h00) begin n_errors++; $display("FAIL rst_output: got %h want 00", bus.Output); end
    n_checks++; if (bus.IR !== 3'b000) begin n_errors++; $display("FAIL rst_ir: got %b want 000", bus.IR); end
    n_checks++; if (bus.Aeq0 !== 1'b1) begin n_errors++; $display("FAIL rst_aeq0: got %b want 1", bus.Aeq0); end
    n_checks++; if (bus.Apos !== 1'b0) begin n_errors++; $display("FAIL rst_apos: got %b want 0", bus.Apos); end
    load_in(8'hFF);
    n_checks++; if (bus.Output !== 8'h00) begin n_errors++; $display("FAIL rst_hold_A: got %h want 00", bus.Output); end
    Reset = 1'b1;
    step(0,1,0,0,0,2'b01,1,0,0,8'h35);
    for (int i = 0; i < 6; i++) step(0,1,0,0,0,2'b00,0,0,0,8'h00);
    n_checks++; if (bus.Output !== 8'h35) begin n_errors++; $display("FAIL pre_rst_A: got %h want 35", bus.Output); end
    n_checks++; if (bus.Apos !== 1'b1) begin n_errors++; $display("FAIL pre_rst_apos: got %b want 1", bus.Apos); end
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.Output !== 8'h00) begin n_errors++; $display("FAIL async_rst_A: got %h want 00", bus.Output); end
    n_checks++; if (bus.Aeq0 !== 1'b1) begin n_errors++; $display("FAIL async_rst_aeq0: got %b want 1", bus.Aeq0); end
    @(posedge Clock);
    #1;
    idle();
    Reset = 1'b1;
  endtask

  // Fills RAM through the datapath: each cycle writes the pre-edge A while A loads the next word.
  task automatic init_ram();
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom);
    prog[0] = 8'h05; prog[1] = 8'h00; prog[2] = 8'h06; prog[3] = 8'h1F;
    prog[5] = 8'h2A; prog[6] = 8'h01; prog[12] = 8'hA0; prog[13] = 8'h1F;
    prog[14] = 8'h6B; prog[31] = 8'hEC;
    load_in(prog[0]);
    for (int i = 0; i < DEPTH; i++) step(0,1,0,0,1,2'b01,1,0,0,prog[(i+1)%DEPTH]);
    n_checks++; if (bus.Output !== prog[0]) begin n_errors++; $display("FAIL init_A: got %h want %h", bus.Output, prog[0]); end
  endtask

  task automatic test_fetch_load();
    fetch();
    n_checks++; if (bus.IR !== 3'b000) begin n_errors++; $display("FAIL fetch_ir: got %b want 000", bus.IR); end
    decode();
    load_mdr();
    n_checks++; if (bus.Output !== 8'h2A) begin n_errors++; $display("FAIL load_A: got %h want 2a", bus.Output); end
    n_checks++; if (bus.Apos !== 1'b1) begin n_errors++; $display("FAIL load_apos: got %b want 1", bus.Apos); end
  endtask

  task automatic test_alu_flags();
    fetch(); decode();
    load_in(8'h03);
    step(0,0,0,0,0,2'b00,1,1,0,8'h00);
    n_checks++; if (bus.Output !== 8'hFE) begin n_errors++; $display("FAIL sub_A: got %h want fe", bus.Output); end
    n_checks++; if (bus.Aeq0 !== 1'b0 || bus.Apos !== 1'b0) begin n_errors++; $display("FAIL sub_flags: got %b%b want 00", bus.Aeq0, bus.Apos); end
    fetch(); decode();
    load_in(8'h7F);
    step(0,0,0,0,0,2'b00,1,0,0,8'h00);
    n_checks++; if (bus.Output !== 8'h80 || bus.Apos !== 1'b0) begin n_errors++; $display("FAIL add_wrap: got %h/%b want 80/0", bus.Output, bus.Apos); end
    step(0,0,0,0,0,2'b11,1,0,0,8'h00);
    n_checks++; if (bus.Output !== 8'h00 || bus.Aeq0 !== 1'b1) begin n_errors++; $display("FAIL clear_A: got %h/%b want 00/1", bus.Output, bus.Aeq0); end
    step(0,0,0,0,0,2'b01,0,0,0,8'h99);
    n_checks++; if (bus.Output !== 8'h00) begin n_errors++; $display("FAIL hold_A: got %h want 00", bus.Output); end
  endtask

  task automatic test_pc();
    fetch();                                 // IR=0x1F, PC=4
    step(0,1,1,0,0,2'b00,0,0,0,8'h00);       // PC=31
    step(1,0,0,0,0,2'b00,0,0,0,8'h00);       // IR=RAM[31]=0xEC
    n_checks++; if (bus.IR !== 3'b111) begin n_errors++; $display("FAIL jump31_ir: got %b want 111", bus.IR); end
    step(0,0,1,0,0,2'b00,0,0,0,8'h00);       // PCload low: PC stays 31
    fetch();
    n_checks++; if (bus.IR !== 3'b111) begin n_errors++; $display("FAIL pc_hold_ir: got %b want 111", bus.IR); end
    step(1,1,1,0,0,2'b00,0,0,0,8'h00);       // IR=RAM[0], PC=12
    n_checks++; if (bus.IR !== 3'b000) begin n_errors++; $display("FAIL pc_wrap_ir: got %b want 000", bus.IR); end
    fetch();
    n_checks++; if (bus.IR !== 3'b101) begin n_errors++; $display("FAIL jump12_ir: got %b want 101", bus.IR); end
  endtask

  task automatic test_memwr_halt();
    fetch();                                 // IR=0x1F, PC=14
    load_in(8'h11);
    step(0,0,0,1,1,2'b00,0,0,0,8'h00);       // RAM[31]=0x11, MDR kept
    load_mdr();
    n_checks++; if (bus.Output !== 8'h01) begin n_errors++; $display("FAIL memwr_mdr_kept: got %h want 01", bus.Output); end
    decode();
    load_mdr();
    n_checks++; if (bus.Output !== 8'h11) begin n_errors++; $display("FAIL memwr_ram31: got %h want 11", bus.Output); end
    step(1,1,0,0,1,2'b11,1,0,1,8'h00);
    n_checks++; if (bus.Output !== 8'h11 || bus.IR !== 3'b000) begin n_errors++; $display("FAIL halt_state: got %h/%b want 11/000", bus.Output, bus.IR); end
    fetch();
    n_checks++; if (bus.IR !== 3'b011) begin n_errors++; $display("FAIL halt_pc: got %b want 011", bus.IR); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(7) == 0), 8'($urandom));
      n_checks++; if (bus.Output !== m_a) begin n_errors++; $display("FAIL rnd_A[%0d]: got %h want %h", n, bus.Output, m_a); end
      n_checks++; if (bus.IR !== m_ir[7:5]) begin n_errors++; $display("FAIL rnd_ir[%0d]: got %b want %b", n, bus.IR, m_ir[7:5]); end
      n_checks++; if (bus.Aeq0 !== (m_a == 8'h00)) begin n_errors++; $display("FAIL rnd_aeq0[%0d]: got %b for A=%h", n, bus.Aeq0, m_a); end
      n_checks++; if (bus.Apos !== ($signed(m_a) > 0)) begin n_errors++; $display("FAIL rnd_apos[%0d]: got %b for A=%h", n, bus.Apos, m_a); end
    end
  endtask

`ifdef ACCUM_DP_PROG_EN
  task automatic test_prog();
    Reset = 1'b0;
    model_reset();
    ProgWr = 1'b1; ProgAddr = 5'd3; ProgData = 8'hA7;
    idle();
    Reset = 1'b1;
    ProgData = 8'h5B;
    idle();
    ProgWr = 1'b0;
    load_in(8'h03);
    step(0,0,0,0,1,2'b00,0,0,0,8'h00);       // RAM[0]=0x03
    fetch(); decode(); load_mdr();
    n_checks++; if (bus.Output !== 8'hA7) begin n_errors++; $display("FAIL prog_ram3: got %h want a7", bus.Output); end
    n_checks++; if (bus.Output !== m_a) begin n_errors++; $display("FAIL prog_model: got %h want %h", bus.Output, m_a); end
  endtask
`endif

  initial begin
    Reset = 1'b0;
    bus.IRload = 0; bus.PCload = 0; bus.JMPmux = 0; bus.Meminst = 0; bus.MemWr = 0;
    bus.Asel = 2'b00; bus.Aload = 0; bus.Sub = 0; bus.Halt = 0; bus.Input = 8'h00;
    model_reset();
    test_reset();
    init_ram();
    test_fetch_load();
    test_alu_flags();
    test_pc();
    test_memwr_halt();
    test_random();
`ifdef ACCUM_DP_PROG_EN
    test_prog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
